// File: rtl/arb_seq_ctrl_pkg.sv
// Shared types and constants for the arbitrary-sequence run-control block.
// Holds both fixed count sequences and the run-control state encoding.
package arb_seq_ctrl_pkg;

  localparam int unsigned SEQ_LEN = 10;
  localparam int unsigned W       = 4;
  localparam int unsigned IW      = 4;
  localparam int unsigned PW      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] SEQ_PRI [SEQ_LEN] = '{
    W'(4), W'(11), W'(2), W'(0), W'(4), W'(2), W'(10), W'(3), W'(15), W'(1)
  };

  localparam logic [W-1:0] SEQ_ALT [SEQ_LEN] = '{
    W'(0), W'(11), W'(6), W'(5), W'(4), W'(2), W'(10), W'(3), W'(15), W'(1)
  };

  // Out-of-range indices read as zero so the lookup stays fully defined.
  function automatic logic [W-1:0] seq_val(input logic sel, input logic [IW-1:0] i);
    logic [W-1:0] v;
    v = '0;
    if (i < IW'(SEQ_LEN)) begin
      v = sel ? SEQ_ALT[i] : SEQ_PRI[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/arb_seq_ctrl_if.sv
// Control and status bundle between the top-level controller and the sequencer.
interface arb_seq_ctrl_if;
  import arb_seq_ctrl_pkg::*;

  logic          start;
  logic          stop;
  logic          pause;
  logic          mode;
  logic [PW-1:0] loops;
  logic [W-1:0]  Q;
  logic          run;
  logic          paused;
  logic          done;
  logic          wrap;
  logic [IW-1:0] idx;

  modport master (
    output start, stop, pause, mode, loops,
    input  Q, run, paused, done, wrap, idx
  );

  modport slave (
    input  start, stop, pause, mode, loops,
    output Q, run, paused, done, wrap, idx
  );

endinterface

// File: rtl/arb_seq_rom.sv
// Combinational (mode, index) -> sequence value lookup.
module arb_seq_rom import arb_seq_ctrl_pkg::*; (
  input  logic          mode,
  input  logic [IW-1:0] idx,
  output logic [W-1:0]  val_c
);

  always_comb val_c = seq_val(mode, idx);

endmodule

// File: rtl/arb_seq_ctrl.sv
// Run-control sequencer: steps a 4-bit count through one of two fixed
// 10-entry sequences with start/stop/pause, pass limit, wrap pulse and done.
module arb_seq_ctrl import arb_seq_ctrl_pkg::*; (
  input logic          C,
  input logic          R,
  arb_seq_ctrl_if.slave bus
);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  q_q, q_d;
  logic [PW-1:0] pass_q, pass_d, pass_inc;
  logic [PW-1:0] loops_q, loops_d;
  logic          mode_q, mode_d;
  logic          wrap_q, wrap_d;

  logic          rom_mode;
  logic [IW-1:0] rom_idx;
  logic [W-1:0]  rom_val;
  logic          at_end;
  logic          advance;
  logic          limit_hit;

  // A single lookup serves both the in-pass step and every reload to entry 0.
  arb_seq_rom u_rom (
    .mode  (rom_mode),
    .idx   (rom_idx),
    .val_c (rom_val)
  );

  always_comb begin
    at_end    = (idx_q == IW'(SEQ_LEN - 1));
    advance   = (state_q == RUN) && !bus.stop && !bus.start && !bus.pause;
    pass_inc  = pass_q + PW'(1);
    limit_hit = (loops_q != '0) && (pass_inc == loops_q);
    rom_mode  = bus.mode;
    rom_idx   = '0;
    if (advance && !at_end) begin
      rom_mode = mode_q;
      rom_idx  = idx_q + IW'(1);
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      idx_q   <= '0;
      q_q     <= SEQ_PRI[0];
      pass_q  <= '0;
      loops_q <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      pass_q  <= pass_d;
      loops_q <= loops_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state and datapath update; command priority is stop > start > pause.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    q_d     = q_q;
    pass_d  = pass_q;
    loops_d = loops_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;

    if (bus.stop) begin
      state_d = IDLE;
      idx_d   = '0;
      mode_d  = bus.mode;
      q_d     = rom_val;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d  = '0;
          mode_d = bus.mode;
          q_d    = rom_val;
          if (bus.start) begin
            state_d = RUN;
            pass_d  = '0;
            loops_d = bus.loops;
          end
        end

        RUN: begin
          if (bus.start) begin
            idx_d   = '0;
            pass_d  = '0;
            mode_d  = bus.mode;
            loops_d = bus.loops;
            q_d     = rom_val;
          end else if (bus.pause) begin
            state_d = PAUSE;
          end else if (!at_end) begin
            idx_d = idx_q + IW'(1);
            q_d   = rom_val;
          end else begin
            wrap_d = 1'b1;
            pass_d = pass_inc;
            if (limit_hit) begin
              state_d = DONE;
            end else begin
              idx_d  = '0;
              mode_d = bus.mode;
              q_d    = rom_val;
            end
          end
        end

        PAUSE: begin
          if (bus.start) begin
            state_d = RUN;
            idx_d   = '0;
            pass_d  = '0;
            mode_d  = bus.mode;
            loops_d = bus.loops;
            q_d     = rom_val;
          end else if (!bus.pause) begin
            state_d = RUN;
          end
        end

        DONE: begin
          if (bus.start) begin
            state_d = RUN;
            idx_d   = '0;
            pass_d  = '0;
            mode_d  = bus.mode;
            loops_d = bus.loops;
            q_d     = rom_val;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.Q      = q_q;
  assign bus.idx    = idx_q;
  assign bus.wrap   = wrap_q;
  assign bus.run    = (state_q == RUN);
  assign bus.paused = (state_q == PAUSE);
  assign bus.done   = (state_q == DONE);

endmodule
